pic_int_sequencer: RTL and testbench

- Control block between the IRR register and the CPU bus interface of the 8259-style PIC.
- Resolves priority among unmasked pending requests and gates them against the in-service register (ISR).
- Drives INT and runs the two-pulse INTA acknowledge sequence, returning the chosen one-hot to the IRR block.
- Owns ISR and EOI/rotation handling.

---
 rtl/pic_pkg.sv | 23 ++
 rtl/pic_priority_resolver.sv | 50 +++++
 rtl/pic_int_sequencer.sv | 152 +++++++++++++++
 tb/tb_pic_int_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-style interrupt sequencer.
package pic_pkg;

   localparam int NUM_IRQ = 8;
   localparam int LVL_W   = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK1 = 2'd1,
      ACK2 = 2'd2
   } state_t;

   // Level reported when an acknowledge arrives with nothing eligible
   localparam logic [LVL_W-1:0] SPURIOUS_LVL    = 3'd7;
   // IR7 lowest after reset, so IR0 is the highest priority
   localparam logic [LVL_W-1:0] LOWEST_PRIO_RST = 3'd7;

   function automatic logic [NUM_IRQ-1:0] lvl_onehot(input logic [LVL_W-1:0] lvl);
      lvl_onehot      = '0;
      lvl_onehot[lvl] = 1'b1;
   endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating priority encoder: picks the highest-priority pending level and
// the highest-priority in-service level, and decides whether the pending
// winner is allowed to nest above what is already in service.
module pic_priority_resolver import pic_pkg::*; (
   input  logic [NUM_IRQ-1:0] i_pend,
   input  logic [NUM_IRQ-1:0] i_isr,
   input  logic [LVL_W-1:0]   i_lowest_prio,
   output logic               o_has_req,
   output logic [LVL_W-1:0]   o_win_lvl,
   output logic               o_isr_any,
   output logic [LVL_W-1:0]   o_isr_lvl
);

   // w_lvl[k] is the level holding rank k (rank 0 = highest priority)
   logic [LVL_W-1:0]   w_lvl [NUM_IRQ];
   logic [NUM_IRQ-1:0] w_pend_rot;
   logic [NUM_IRQ-1:0] w_isr_rot;
   logic               w_pend_any;
   logic [LVL_W-1:0]   w_win_rank;
   logic [LVL_W-1:0]   w_isr_rank;

   for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_rot
      assign w_lvl[gi]      = i_lowest_prio + LVL_W'(gi + 1);
      assign w_pend_rot[gi] = i_pend[w_lvl[gi]];
      assign w_isr_rot[gi]  = i_isr[w_lvl[gi]];
   end

   // Scan from lowest rank upward so the last hit is the highest priority
   always_comb begin
      w_pend_any = 1'b0;
      w_win_rank = '0;
      o_isr_any  = 1'b0;
      w_isr_rank = '0;
      for (int k = NUM_IRQ - 1; k >= 0; k--) begin
         if (w_pend_rot[k]) begin
            w_pend_any = 1'b1;
            w_win_rank = LVL_W'(k);
         end
         if (w_isr_rot[k]) begin
            o_isr_any  = 1'b1;
            w_isr_rank = LVL_W'(k);
         end
      end
      o_win_lvl = w_lvl[w_win_rank];
      o_isr_lvl = w_lvl[w_isr_rank];
      // Fully nested: a request must strictly outrank the top in-service level
      o_has_req = w_pend_any && (!o_isr_any || (w_win_rank < w_isr_rank));
   end

endmodule

// File: rtl/pic_int_sequencer.sv
// 8259-style interrupt sequencer: priority resolution, INT generation,
// two-pulse INTA acknowledge, ISR ownership and EOI/rotation handling.
// Optional feature macro: PIC_AUTO_EOI_EN (automatic EOI at end of INTA).
module pic_int_sequencer #(
   parameter int NUM_IRQ = pic_pkg::NUM_IRQ,
   parameter int LVL_W   = pic_pkg::LVL_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_IRQ-1:0] IRR,
   input  logic [NUM_IRQ-1:0] IMR,
   input  logic               INTA_N,
   input  logic               eoi_cmd,
   input  logic               eoi_specific,
   input  logic               eoi_rotate,
   input  logic [LVL_W-1:0]   eoi_level,
   input  logic [4:0]         icw2_base,
   input  logic               aeoi,
   output logic               INT,
   output logic [NUM_IRQ-1:0] chosen,
   output logic [NUM_IRQ-1:0] ISR,
   output logic [7:0]         vector,
   output logic               vector_en
);
   import pic_pkg::*;

   state_t             r_state;
   logic               r_inta_n;
   logic [LVL_W-1:0]   r_win;
   logic               r_spurious;
   logic [LVL_W-1:0]   r_lowest_prio;
   logic               r_int;
   logic [NUM_IRQ-1:0] r_chosen;
   logic [NUM_IRQ-1:0] r_isr;
   logic [7:0]         r_vector;
   logic               r_vector_en;

   logic               w_fall;
   logic               w_rise;
   logic               w_has_req;
   logic [LVL_W-1:0]   w_win_lvl;
   logic               w_isr_any;
   logic [LVL_W-1:0]   w_isr_lvl;
   logic [NUM_IRQ-1:0] w_eoi_clr;
   logic [NUM_IRQ-1:0] w_aeoi_clr;
   logic [NUM_IRQ-1:0] w_isr_set;
   logic [NUM_IRQ-1:0] w_isr_next;
   logic               w_rot_en;
   logic [LVL_W-1:0]   w_rot_lvl;

   assign w_fall = r_inta_n & ~INTA_N;
   assign w_rise = ~r_inta_n & INTA_N;

   pic_priority_resolver u_resolver (
      .i_pend        (IRR & ~IMR),
      .i_isr         (r_isr),
      .i_lowest_prio (r_lowest_prio),
      .o_has_req     (w_has_req),
      .o_win_lvl     (w_win_lvl),
      .o_isr_any     (w_isr_any),
      .o_isr_lvl     (w_isr_lvl)
   );

   // EOI decode: which ISR bit to clear and whether priority rotates
   always_comb begin
      w_eoi_clr = '0;
      w_rot_en  = 1'b0;
      w_rot_lvl = r_lowest_prio;
      if (eoi_cmd) begin
         if (eoi_specific) begin
            w_eoi_clr = lvl_onehot(eoi_level);
            w_rot_en  = eoi_rotate;
            w_rot_lvl = eoi_level;
         end else if (w_isr_any) begin
            w_eoi_clr = lvl_onehot(w_isr_lvl);
            w_rot_en  = eoi_rotate;
            w_rot_lvl = w_isr_lvl;
         end
      end
   end

`ifdef PIC_AUTO_EOI_EN
   // Automatic EOI retires the acknowledged level as INTA completes
   assign w_aeoi_clr = (r_state == ACK2 && w_rise && aeoi && !r_spurious)
                       ? lvl_onehot(r_win) : '0;
`else
   logic w_unused_aeoi;
   assign w_unused_aeoi = aeoi;
   assign w_aeoi_clr    = '0;
`endif

   // A new acknowledge wins over a same-cycle clear of the same bit
   assign w_isr_set  = (r_state == IDLE && w_fall && w_has_req) ? lvl_onehot(w_win_lvl) : '0;
   assign w_isr_next = (r_isr & ~(w_eoi_clr | w_aeoi_clr)) | w_isr_set;

   // Acknowledge FSM with registered INT/chosen/vector outputs and ISR state
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= IDLE;
         r_inta_n      <= 1'b1;
         r_win         <= SPURIOUS_LVL;
         r_spurious    <= 1'b0;
         r_lowest_prio <= LOWEST_PRIO_RST;
         r_int         <= 1'b0;
         r_chosen      <= '0;
         r_isr         <= '0;
         r_vector      <= '0;
         r_vector_en   <= 1'b0;
      end else begin
         r_inta_n <= INTA_N;
         r_isr    <= w_isr_next;
         r_chosen <= '0;
         r_int    <= 1'b0;
         if (w_rot_en) begin
            r_lowest_prio <= w_rot_lvl;
         end
         unique case (r_state)
            IDLE: begin
               r_int <= w_has_req;
               if (w_fall) begin
                  r_state    <= ACK1;
                  r_int      <= 1'b0;
                  r_spurious <= !w_has_req;
                  r_win      <= w_has_req ? w_win_lvl : SPURIOUS_LVL;
                  r_chosen   <= w_has_req ? lvl_onehot(w_win_lvl) : '0;
               end
            end
            ACK1: begin
               if (w_fall) begin
                  r_state     <= ACK2;
                  r_vector    <= {icw2_base, r_win};
                  r_vector_en <= 1'b1;
               end
            end
            ACK2: begin
               if (w_rise) begin
                  r_state     <= IDLE;
                  r_vector_en <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign INT       = r_int;
   assign chosen    = r_chosen;
   assign ISR       = r_isr;
   assign vector    = r_vector;
   assign vector_en = r_vector_en;

endmodule

// File: tb/tb_pic_int_sequencer.sv
// Scoreboard bench for pic_int_sequencer: stimulus pushes expected chosen
// pulses and vectors; a monitor pops and compares when the DUT presents them.
module tb_pic_int_sequencer;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] IRR = '0;
   logic [7:0] IMR = '0;
   logic       INTA_N = 1'b1;
   logic       eoi_cmd = 1'b0;
   logic       eoi_specific = 1'b0;
   logic       eoi_rotate = 1'b0;
   logic [2:0] eoi_level = '0;
   logic [4:0] icw2_base = '0;
   logic       aeoi = 1'b0;
   logic       INT;
   logic [7:0] chosen;
   logic [7:0] ISR;
   logic [7:0] vector;
   logic       vector_en;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_chosen_q [$];
   logic [7:0] exp_vector_q [$];

   always #5 CLK = ~CLK;

   pic_int_sequencer dut (
      .CLK          (CLK),
      .RST          (RST),
      .IRR          (IRR),
      .IMR          (IMR),
      .INTA_N       (INTA_N),
      .eoi_cmd      (eoi_cmd),
      .eoi_specific (eoi_specific),
      .eoi_rotate   (eoi_rotate),
      .eoi_level    (eoi_level),
      .icw2_base    (icw2_base),
      .aeoi         (aeoi),
      .INT          (INT),
      .chosen       (chosen),
      .ISR          (ISR),
      .vector       (vector),
      .vector_en    (vector_en)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Two INTA pulses; exp_ch == 0 means a spurious ack (no chosen pulse)
   task automatic ack_seq(input logic [7:0] exp_ch, input logic [7:0] exp_vec);
      if (exp_ch != 8'h00) exp_chosen_q.push_back(exp_ch);
      exp_vector_q.push_back(exp_vec);
      INTA_N = 1'b0; tick(); tick();
      INTA_N = 1'b1; tick(); tick();
      INTA_N = 1'b0; tick(); tick();
      INTA_N = 1'b1; tick(); tick();
   endtask

   // Monitor: one line per observed transaction
   initial begin
      logic       ven_prev;
      logic [7:0] e;
      ven_prev = 1'b0;
      forever begin
         @(negedge CLK);
         if (chosen !== 8'h00) begin
            if (exp_chosen_q.size() == 0) begin
               chk("chosen_unexpected", {24'h0, chosen}, 32'h0);
            end else begin
               e = exp_chosen_q.pop_front();
               $display("[TB] chosen pulse %02h (expected %02h)", chosen, e);
               chk("chosen", {24'h0, chosen}, {24'h0, e});
            end
         end
         if (vector_en === 1'b1 && ven_prev === 1'b0) begin
            if (exp_vector_q.size() == 0) begin
               chk("vector_unexpected", {24'h0, vector}, 32'h0);
            end else begin
               e = exp_vector_q.pop_front();
               $display("[TB] vector %02h (expected %02h)", vector, e);
               chk("vector", {24'h0, vector}, {24'h0, e});
            end
         end
         ven_prev = vector_en;
      end
   end

   initial begin
      tick(); tick(); tick();
      chk("rst_int", {31'h0, INT}, 32'h0);
      chk("rst_chosen", {24'h0, chosen}, 32'h0);
      chk("rst_isr", {24'h0, ISR}, 32'h0);
      chk("rst_vector", {24'h0, vector}, 32'h0);
      chk("rst_vector_en", {31'h0, vector_en}, 32'h0);
      RST = 1'b0;

      // Basic ack: IR1 and IR3 pending, IR1 wins
      icw2_base = 5'h01;
      IRR = 8'h0A; tick(); tick();
      chk("t1_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h02, 8'h09);
      chk("t1_isr", {24'h0, ISR}, 32'h02);
      chk("t1_vector_hold", {24'h0, vector}, 32'h09);
      chk("t1_vector_en_low", {31'h0, vector_en}, 32'h0);
      IRR = 8'h08; tick(); tick();
      chk("t1_nested_block", {31'h0, INT}, 32'h0);

      // Non-specific EOI clears IR1; then build ISR=04
      eoi_cmd = 1'b1; IRR = 8'h04; tick();
      eoi_cmd = 1'b0; tick();
      chk("t2_isr_clr", {24'h0, ISR}, 32'h00);
      chk("t2_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h04, 8'h0A);
      chk("t2_isr04", {24'h0, ISR}, 32'h04);
      IRR = 8'h10; tick(); tick();
      chk("t2_lower_blocked", {31'h0, INT}, 32'h0);
      IRR = 8'h11; tick(); tick();
      chk("t2_higher_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h01, 8'h08);
      chk("t2_isr05", {24'h0, ISR}, 32'h05);
      IRR = 8'h00;

      // Non-specific EOI with rotation: IR0 cleared and becomes lowest
      eoi_cmd = 1'b1; eoi_rotate = 1'b1; tick();
      eoi_cmd = 1'b0; eoi_rotate = 1'b0;
      chk("t3_isr", {24'h0, ISR}, 32'h04);
      IRR = 8'h03; tick(); tick();
      chk("t3_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h02, 8'h09);
      chk("t3_isr06", {24'h0, ISR}, 32'h06);
      IRR = 8'h00;

      // Spurious ack: request vanishes one cycle before INTA
      eoi_cmd = 1'b1; tick(); tick();
      eoi_cmd = 1'b0;
      chk("t4_isr_cleared", {24'h0, ISR}, 32'h00);
      icw2_base = 5'h10;
      IRR = 8'h08; tick(); tick();
      chk("t4_int", {31'h0, INT}, 32'h1);
      IRR = 8'h00; tick();
      ack_seq(8'h00, 8'h87);
      chk("t4_isr_unchanged", {24'h0, ISR}, 32'h00);
      chk("t4_vector", {24'h0, vector}, 32'h87);

      // Reset in ACK2
      IRR = 8'h40; tick(); tick();
      exp_chosen_q.push_back(8'h40);
      exp_vector_q.push_back(8'h86);
      INTA_N = 1'b0; tick(); tick();
      INTA_N = 1'b1; tick(); tick();
      INTA_N = 1'b0; tick();
      chk("t5_in_ack2", {31'h0, vector_en}, 32'h1);
      RST = 1'b1; IRR = 8'h00; tick();
      chk("t5_rst_vector_en", {31'h0, vector_en}, 32'h0);
      chk("t5_rst_isr", {24'h0, ISR}, 32'h00);
      chk("t5_rst_int", {31'h0, INT}, 32'h0);
      chk("t5_rst_vector", {24'h0, vector}, 32'h00);
      INTA_N = 1'b1; tick();
      RST = 1'b0; tick();
      IRR = 8'h80; tick(); tick();
      chk("t5_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h80, 8'h87);
      chk("t5_isr80", {24'h0, ISR}, 32'h80);
      // Priority reset restored IR0 as highest: it nests above IR7
      IRR = 8'h01; tick(); tick();
      chk("t5_nest_int", {31'h0, INT}, 32'h1);
      ack_seq(8'h01, 8'h80);
      chk("t5_isr81", {24'h0, ISR}, 32'h81);
      IRR = 8'h00;

      // Specific EOIs, including one on an idle level and one rotating
      eoi_cmd = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd7; tick();
      chk("t6_spec7", {24'h0, ISR}, 32'h01);
      eoi_level = 3'd5; tick();
      chk("t6_spec_idle", {24'h0, ISR}, 32'h01);
      eoi_level = 3'd0; eoi_rotate = 1'b1; tick();
      eoi_cmd = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0;
      chk("t6_spec0", {24'h0, ISR}, 32'h00);
      IRR = 8'h81; tick(); tick();
      ack_seq(8'h80, 8'h87);
      chk("t6_rotated_isr", {24'h0, ISR}, 32'h80);
      IRR = 8'h00;

      // Masked request never raises INT
      IMR = 8'h02; IRR = 8'h02; tick(); tick();
      chk("t7_masked", {31'h0, INT}, 32'h0);
      IMR = 8'h00; IRR = 8'h00;

`ifdef PIC_AUTO_EOI_EN
      // Automatic EOI retires the level on the final INTA rise
      eoi_cmd = 1'b1; tick();
      eoi_cmd = 1'b0; aeoi = 1'b1;
      IRR = 8'h20; tick(); tick();
      exp_chosen_q.push_back(8'h20);
      exp_vector_q.push_back(8'h85);
      INTA_N = 1'b0; tick();
      chk("t8_isr_ack1", {24'h0, ISR}, 32'h20);
      tick();
      INTA_N = 1'b1; tick(); tick();
      INTA_N = 1'b0; tick();
      chk("t8_isr_ack2", {24'h0, ISR}, 32'h20);
      IRR = 8'h00; tick();
      INTA_N = 1'b1; tick();
      chk("t8_isr_aeoi", {24'h0, ISR}, 32'h00);
      aeoi = 1'b0; tick();
`endif

      tick(); tick();
      chk("chosen_q_drained", exp_chosen_q.size(), 32'h0);
      chk("vector_q_drained", exp_vector_q.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
